sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 8: data word width in bits.
REQ-002 SHALL have parameter ASIZE, default 4: address width; depth = 2**ASIZE words.
REQ-003 SHALL have parameter AF_LEVEL, default 2**ASIZE-2: walmost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 2: ralmost_empty asserts when count <= AE_LEVEL.
REQ-005 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-007 SHALL have port win  in  1: write request.
REQ-008 SHALL have port wdata  in  DSIZE: write data, sampled with win.
REQ-009 SHALL have port rout  in  1: read request.
REQ-010 SHALL have port rdata  out  DSIZE: read data.
REQ-011 SHALL have port wfull  out  1: count == 2**ASIZE.
REQ-012 SHALL have port rempty  out  1: count == 0.
REQ-013 SHALL have port walmost_full  out  1: programmable almost-full.
REQ-014 SHALL have port ralmost_empty  out  1: programmable almost-empty.
REQ-015 SHALL have port count  out  ASIZE+1: current occupancy, 0..2**ASIZE.
REQ-016 SHALL have port err_clr  in  1: clears overflow and underflow.
REQ-017 SHALL have port overflow  out  1: sticky; a write was attempted while wfull.
REQ-018 SHALL have port underflow  out  1: sticky; a read was attempted while rempty.

Function
REQ-019 Write accepted iff win && !wfull; wdata stored at wptr, wptr increments modulo 2**ASIZE.
REQ-020 Read accepted iff rout && !rempty; rptr increments modulo 2**ASIZE.
REQ-021 Acceptance uses flag values from before the edge; a write is never accepted while wfull, even with a simultaneous accepted read.
REQ-022 count: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-023 wfull, rempty, walmost_full and ralmost_empty are registered and reflect the updated count in the cycle after the edge that changed it.
REQ-024 Pointer wrap from 2**ASIZE-1 to 0 is seamless; data order is strict FIFO across wrap.
REQ-025 win && wfull sets overflow; rout && rempty sets underflow; rejected requests change no other state.
REQ-026 err_clr clears both error flags; an error event in the same cycle as err_clr takes priority and leaves the flag set.
REQ-027 Without SYNC_FIFO_FWFT_EN: rdata is registered, updates one cycle after an accepted read, and otherwise holds its value.

Reset
REQ-028 When rst is high at a clk edge: wptr=0, rptr=0, count=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=0, overflow=0, underflow=0, rdata=0.
REQ-029 rst overrides any simultaneous win, rout or err_clr; storage contents are not cleared.
REQ-030 Reset mid-operation discards all stored words; the first write after reset is the first word read.

Configuration
REQ-031 Macro SYNC_FIFO_FWFT_EN SHALL select first-word-fall-through mode.
REQ-032 With SYNC_FIFO_FWFT_EN: rdata presents the head word whenever !rempty, with zero read latency; rout pops that word, and rdata is don't-care while rempty.
REQ-033 Without SYNC_FIFO_FWFT_EN: standard mode as specified in REQ-027; all flags and the count behave identically in both modes.

Structure
REQ-034 Package sync_fifo_pkg SHALL hold the default DSIZE and ASIZE constants and the helper function that sizes the count width.
REQ-035 Storage SHALL be a sub-module sync_fifo_mem: a 2**ASIZE x DSIZE array with one synchronous write port and one read port (registered or combinational per mode); control logic stays in sync_fifo.

Verification
REQ-036 Fill/drain: reset, write 0x01..0x10 (16 words, ASIZE=4) -> wfull=1 and count=16; read 16 words -> 0x01..0x10 in order, then rempty=1.
REQ-037 Overflow: when full, win=1 with wdata=0xAA -> write rejected, overflow=1, count=16; err_clr -> overflow=0.
REQ-038 Underflow and simultaneous operations: when empty, rout=1 -> underflow=1, count=0; with count=5, win and rout together for 20 cycles -> count stays 5 and order is preserved across pointer wrap.
REQ-039 Thresholds: AF_LEVEL=14, AE_LEVEL=2 -> walmost_full rises the cycle after the 14th write; ralmost_empty falls the cycle after the 3rd write.
REQ-040 Reset mid-stream: with count=7, assert rst for 1 cycle -> count=0, rempty=1; then write 0x5C and read -> rdata=0x5C.
REQ-041 Modes: write 0x3D into an empty FIFO -> with SYNC_FIFO_FWFT_EN, rdata=0x3D before rout; without it, rdata=0x3D in the cycle after the accepted rout.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helper for the synchronous FIFO.
package sync_fifo_pkg;

  localparam int DSIZE_DEFAULT = 8;
  localparam int ASIZE_DEFAULT = 4;

  // Occupancy runs 0..2**asize inclusive, so it needs one bit more than the pointers.
  function automatic int count_width(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port and one read port.
// SYNC_FIFO_FWFT_EN selects a combinational read port; otherwise the read is registered.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT,
  parameter int ASIZE = ASIZE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic             re_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_q [DEPTH];

  // Array contents survive reset; only the pointers in the controller are cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd;
  assign unused_rd = re_i ^ rst;
  assign rdata_o   = mem_q[raddr_i];
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO controller with registered status flags and sticky error flags.
// SYNC_FIFO_FWFT_EN selects first-word-fall-through reads; flags and count are mode-independent.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE    = DSIZE_DEFAULT,
  parameter int ASIZE    = ASIZE_DEFAULT,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           win,
  input  logic [DSIZE-1:0]               wdata,
  input  logic                           rout,
  output logic [DSIZE-1:0]               rdata,
  output logic                           wfull,
  output logic                           rempty,
  output logic                           walmost_full,
  output logic                           ralmost_empty,
  output logic [count_width(ASIZE)-1:0]  count,
  input  logic                           err_clr,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int              CW     = count_width(ASIZE);
  localparam logic [CW-1:0]   DEPTH  = CW'(1 << ASIZE);
  localparam logic [CW-1:0]   AF_THR = CW'(AF_LEVEL);
  localparam logic [CW-1:0]   AE_THR = CW'(AE_LEVEL);

  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wfull_q, rempty_q, afull_q, aempty_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  // Acceptance looks only at the registered flags, so a full FIFO rejects a write
  // even when a read frees a slot on the same edge.
  assign wr_acc = win  && !wfull_q;
  assign rd_acc = rout && !rempty_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A fresh error event outranks a clear arriving in the same cycle.
    if (win && wfull_q)    overflow_d = 1'b1;
    else if (err_clr)      overflow_d = 1'b0;
    if (rout && rempty_q)  underflow_d = 1'b1;
    else if (err_clr)      underflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      wfull_q     <= 1'b0;
      rempty_q    <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      wfull_q     <= (count_d == DEPTH);
      rempty_q    <= (count_d == '0);
      afull_q     <= (count_d >= AF_THR);
      aempty_q    <= (count_d <= AE_THR);
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .re_i    (rd_acc),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign count         = count_q;
  assign wfull         = wfull_q;
  assign rempty        = rempty_q;
  assign walmost_full  = afull_q;
  assign ralmost_empty = aempty_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DSIZE=8, ASIZE=4, AF_LEVEL=14, AE_LEVEL=2).
// Honours SYNC_FIFO_FWFT_EN when checking read data timing.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       win = 1'b0;
  logic [7:0] wdata = '0;
  logic       rout = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rdata;
  logic       wfull, rempty, walmost_full, ralmost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DSIZE    (8),
    .ASIZE    (4),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .win           (win),
    .wdata         (wdata),
    .rout          (rout),
    .rdata         (rdata),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .err_clr       (err_clr),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
    win = w; wdata = d; rout = r; err_clr = c;
    step();
    win = 1'b0; wdata = '0; rout = 1'b0; err_clr = 1'b0;
    $display("txn win=%0b wdata=%02h rout=%0b err_clr=%0b -> count=%0d rdata=%02h", w, d, r, c, count, rdata);
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
  endtask

  // Pops one word and checks it at the point where the active mode presents it.
  task automatic pop(input string tag, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    check(tag, rdata, exp);
    drive(1'b0, '0, 1'b1, 1'b0);
`else
    drive(1'b0, '0, 1'b1, 1'b0);
    check(tag, rdata, exp);
`endif
  endtask

  initial begin
    // Reset state
    step();
    step();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_rempty", rempty, 1);
    check("rst_wfull", wfull, 0);
    check("rst_aempty", ralmost_empty, 1);
    check("rst_afull", walmost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rdata", rdata, 0);
`endif

    // Fill 0x01..0x10 with threshold tracking
    for (int k = 1; k <= 16; k++) begin
      push(8'(k));
      check($sformatf("fill_count_%0d", k), count, k);
      check($sformatf("fill_aempty_%0d", k), ralmost_empty, (k <= 2) ? 1 : 0);
      check($sformatf("fill_afull_%0d", k), walmost_full, (k >= 14) ? 1 : 0);
    end
    check("full_wfull", wfull, 1);
    check("full_rempty", rempty, 0);

    // Overflow and err_clr
    push(8'hAA);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", overflow, 0);
    drive(1'b1, 8'hBB, 1'b0, 1'b1);
    check("ovf_prio", overflow, 1);
    check("ovf_prio_count", count, 16);

    // Full with simultaneous write and read: read wins, write rejected
`ifdef SYNC_FIFO_FWFT_EN
    check("fullrw_rdata", rdata, 8'h01);
    drive(1'b1, 8'hCC, 1'b1, 1'b0);
`else
    drive(1'b1, 8'hCC, 1'b1, 1'b0);
    check("fullrw_rdata", rdata, 8'h01);
`endif
    check("fullrw_count", count, 15);
    check("fullrw_wfull", wfull, 0);
    check("fullrw_ovf", overflow, 1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr2", overflow, 0);

    // Drain remaining 0x02..0x10
    for (int k = 2; k <= 16; k++) begin
      pop($sformatf("drain_%0d", k), 8'(k));
    end
    check("drain_rempty", rempty, 1);
    check("drain_count", count, 0);
    check("drain_aempty", ralmost_empty, 1);

    // Underflow
    drive(1'b0, '0, 1'b1, 1'b0);
    check("udf_set", underflow, 1);
    check("udf_count", count, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("udf_rdata_hold", rdata, 8'h10);
`endif
    drive(1'b0, '0, 1'b0, 1'b1);
    check("udf_clr", underflow, 0);

    // Steady-state simultaneous traffic across pointer wrap
    for (int k = 0; k < 5; k++) push(8'(8'h20 + k));
    check("sim_count0", count, 5);
    for (int k = 0; k < 20; k++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check($sformatf("sim_rdata_%0d", k), rdata, 8'(8'h20 + k));
      drive(1'b1, 8'(8'h25 + k), 1'b1, 1'b0);
`else
      drive(1'b1, 8'(8'h25 + k), 1'b1, 1'b0);
      check($sformatf("sim_rdata_%0d", k), rdata, 8'(8'h20 + k));
`endif
      check($sformatf("sim_count_%0d", k), count, 5);
    end
    for (int k = 0; k < 5; k++) pop($sformatf("sim_tail_%0d", k), 8'(8'h34 + k));
    check("sim_rempty", rempty, 1);
`ifndef SYNC_FIFO_FWFT_EN
    drive(1'b0, '0, 1'b0, 1'b0);
    check("idle_hold", rdata, 8'h38);
`endif

    // Reset mid-stream
    for (int k = 0; k < 7; k++) push(8'(8'h40 + k));
    check("mid_count", count, 7);
    rst = 1'b1;
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    rst = 1'b0;
    check("mid_rst_count", count, 0);
    check("mid_rst_rempty", rempty, 1);
    check("mid_rst_aempty", ralmost_empty, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("mid_rst_rdata", rdata, 0);
`endif
    push(8'h5C);
    pop("post_rst_word", 8'h5C);
    check("post_rst_empty", rempty, 1);

    // Read latency by mode
    push(8'h3D);
`ifndef SYNC_FIFO_FWFT_EN
    check("mode_pre_read_hold", rdata, 8'h5C);
`endif
    pop("mode_word", 8'h3D);
    check("mode_empty", rempty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
